// File: rtl/megaram_mem_arbiter.sv
// ============================================================================
// Module   : megaram_mem_arbiter
// Brief    : Two-port (A/B) round-robin memory arbiter with periodic refresh
//            scheduling. A due refresh waits for idle ports; once it has been
//            deferred long enough it is forced ahead of port traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module megaram_mem_arbiter #(
    parameter logic [15:0] REFRESH_INTERVAL = 16'd420,
    parameter logic [7:0]  REFRESH_MAX_WAIT = 8'd32
) (
    input  logic        clk,
    input  logic        reset_n,
    // Port A (cartridge/CPU)
    input  logic        a_req,
    input  logic        a_wr,
    input  logic [22:0] a_addr,
    input  logic [7:0]  a_din,
    output logic [7:0]  a_dout,
    output logic        a_ack,
    // Port B (loader)
    input  logic        b_req,
    input  logic        b_wr,
    input  logic [22:0] b_addr,
    input  logic [7:0]  b_din,
    output logic [7:0]  b_dout,
    output logic        b_ack,
    // Memory controller side
    output logic        mem_req,
    output logic        mem_wr,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_refresh,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS_A = 2'd1,
        ST_ACCESS_B = 2'd2,
        ST_REFRESH  = 2'd3
    } state_t;

    localparam logic [15:0] c_interval_last = REFRESH_INTERVAL - 16'd1;
    localparam logic [7:0]  c_wait_last     = REFRESH_MAX_WAIT - 8'd1;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_grant_b;
    logic [15:0] r_refresh_cnt;
    logic [7:0]  r_wait_cnt;
    logic        r_refresh_due;
    logic        r_refresh_forced;

    logic        w_a_eligible;
    logic        w_b_eligible;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_grant_refresh;
    logic        w_refresh_done;
    logic        w_interval_wrap;

    assign busy            = (r_state != ST_IDLE);
    assign w_refresh_done  = (r_state == ST_REFRESH) && mem_done;
    assign w_interval_wrap = (r_refresh_cnt == c_interval_last);

    // Grant selection and next-state decode; a port is masked during its own ack cycle
    always_comb begin
        w_a_eligible    = a_req & ~a_ack;
        w_b_eligible    = b_req & ~b_ack;
        w_grant_a       = 1'b0;
        w_grant_b       = 1'b0;
        w_grant_refresh = 1'b0;
        w_state_next    = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_refresh_forced) begin
                    w_grant_refresh = 1'b1;
                end else if (w_a_eligible && w_b_eligible) begin
                    w_grant_a = r_last_grant_b;
                    w_grant_b = ~r_last_grant_b;
                end else if (w_a_eligible) begin
                    w_grant_a = 1'b1;
                end else if (w_b_eligible) begin
                    w_grant_b = 1'b1;
                end else if (r_refresh_due && !a_req && !b_req) begin
                    // Raw requests are used here so a port in its ack cycle still defers refresh
                    w_grant_refresh = 1'b1;
                end
                if (w_grant_refresh) begin
                    w_state_next = ST_REFRESH;
                end else if (w_grant_a) begin
                    w_state_next = ST_ACCESS_A;
                end else if (w_grant_b) begin
                    w_state_next = ST_ACCESS_B;
                end
            end
            ST_ACCESS_A,
            ST_ACCESS_B,
            ST_REFRESH: begin
                if (mem_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and round-robin history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_last_grant_b <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_grant_a) begin
                r_last_grant_b <= 1'b0;
            end else if (w_grant_b) begin
                r_last_grant_b <= 1'b1;
            end
        end
    end

    // Memory request launch, completion handling and read-data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= 23'd0;
            mem_wdata   <= 8'h00;
            mem_refresh <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_dout      <= 8'h00;
            b_dout      <= 8'h00;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_refresh) begin
                        mem_refresh <= 1'b1;
                    end else if (w_grant_a) begin
                        mem_req   <= 1'b1;
                        mem_wr    <= a_wr;
                        mem_addr  <= a_addr;
                        mem_wdata <= a_din;
                    end else if (w_grant_b) begin
                        mem_req   <= 1'b1;
                        mem_wr    <= b_wr;
                        mem_addr  <= b_addr;
                        mem_wdata <= b_din;
                    end
                end
                ST_ACCESS_A: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        a_ack   <= 1'b1;
                        if (!mem_wr) begin
                            a_dout <= mem_rdata;
                        end
                    end
                end
                ST_ACCESS_B: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        b_ack   <= 1'b1;
                        if (!mem_wr) begin
                            b_dout <= mem_rdata;
                        end
                    end
                end
                ST_REFRESH: begin
                    if (mem_done) begin
                        mem_refresh <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Refresh interval timer plus deferral counter that escalates a due refresh to forced
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_refresh_cnt    <= 16'd0;
            r_wait_cnt       <= 8'd0;
            r_refresh_due    <= 1'b0;
            r_refresh_forced <= 1'b0;
        end else begin
            r_refresh_cnt <= w_interval_wrap ? 16'd0 : r_refresh_cnt + 16'd1;
            // A wrap landing on refresh completion opens a new period rather than being lost
            if (w_interval_wrap) begin
                r_refresh_due <= 1'b1;
            end else if (w_refresh_done) begin
                r_refresh_due <= 1'b0;
            end
            if (w_refresh_done) begin
                r_refresh_forced <= 1'b0;
                r_wait_cnt       <= 8'd0;
            end else if (r_refresh_due && !r_refresh_forced &&
                         r_state != ST_REFRESH && !w_grant_refresh) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
                if (r_wait_cnt == c_wait_last) begin
                    r_refresh_forced <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_megaram_mem_arbiter.sv
// ============================================================================
// Module   : tb_megaram_mem_arbiter
// Brief    : Directed self-checking bench for megaram_mem_arbiter with a
//            latency-programmable memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_megaram_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
    logic [22:0] a_addr = 23'd0, b_addr = 23'd0;
    logic [7:0]  a_din = 8'h00, b_din = 8'h00;
    logic [7:0]  a_dout, b_dout;
    logic        a_ack, b_ack;
    logic        mem_req, mem_wr, mem_refresh, busy;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_done;

    int          n_checks = 0;
    int          n_errors = 0;

    // Responder controls, written by the main sequence
    int          lat = 1;
    logic [7:0]  rd_val = 8'h00;
    logic        inj_done = 1'b0;
    int          resp_cnt = 0;

    // Monitor state
    logic [22:0] grant_log[$];
    logic        prev_req = 1'b0;
    int          overlap_cnt = 0;
    int          b_ack_cnt = 0;

    localparam logic [22:0] c_addr_a = 23'h000A0A;
    localparam logic [22:0] c_addr_b = 23'h000B0B;

    megaram_mem_arbiter #(
        .REFRESH_INTERVAL(16'd16),
        .REFRESH_MAX_WAIT(8'd4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_req      (a_req),
        .a_wr       (a_wr),
        .a_addr     (a_addr),
        .a_din      (a_din),
        .a_dout     (a_dout),
        .a_ack      (a_ack),
        .b_req      (b_req),
        .b_wr       (b_wr),
        .b_addr     (b_addr),
        .b_din      (b_din),
        .b_dout     (b_dout),
        .b_ack      (b_ack),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_refresh(mem_refresh),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Memory responder: mem_done arrives in the lat-th cycle after mem_req/mem_refresh rises
    initial begin
        mem_done  = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_rdata = rd_val;
            if (mem_req || mem_refresh) begin
                resp_cnt++;
                if (resp_cnt > lat) begin
                    mem_done = 1'b1;
                    resp_cnt = 0;
                end else begin
                    mem_done = inj_done;
                end
            end else begin
                resp_cnt = 0;
                mem_done = inj_done;
            end
        end
    end

    // Monitor: grant order, refresh/access overlap, b_ack pulse count
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) grant_log.push_back(mem_addr);
            prev_req = mem_req;
            if (mem_req && mem_refresh) overlap_cnt++;
            if (b_ack) b_ack_cnt++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        a_req   = 1'b0;
        b_req   = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    // Returns the number of ticks until the selected ack is seen, or -1 on timeout
    task automatic wait_ack(input logic port_b, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            tick(1);
            if ((port_b ? b_ack : a_ack) == 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int s;
        int same_cnt;
        int b_ack_base;

        // ---------------- A read with 3-cycle memory latency ----------------
        do_reset();
        check_value("rst_busy", busy, 0);
        check_value("rst_mem_req", mem_req, 0);
        check_value("rst_mem_refresh", mem_refresh, 0);
        check_value("rst_a_dout", a_dout, 8'h00);
        lat    = 3;
        rd_val = 8'h5A;
        a_wr   = 1'b0;
        a_addr = 23'h100005;
        a_req  = 1'b1;
        tick(1);
        check_value("a_rd_mem_req", mem_req, 1);
        check_value("a_rd_mem_addr", mem_addr, 23'h100005);
        check_value("a_rd_mem_wr", mem_wr, 0);
        check_value("a_rd_busy", busy, 1);
        tick(3);
        check_value("a_rd_hold_req", mem_req, 1);
        check_value("a_rd_hold_addr", mem_addr, 23'h100005);
        check_value("a_rd_no_ack_yet", a_ack, 0);
        tick(1);
        check_value("a_rd_ack", a_ack, 1);
        check_value("a_rd_dout", a_dout, 8'h5A);
        check_value("a_rd_req_drop", mem_req, 0);
        a_req = 1'b0;
        tick(1);
        check_value("a_rd_ack_pulse", a_ack, 0);

        // ---------------- B write then B read; mem_done in IDLE ----------------
        do_reset();
        lat    = 1;
        b_wr   = 1'b1;
        b_addr = 23'h000123;
        b_din  = 8'hC3;
        b_req  = 1'b1;
        tick(1);
        check_value("b_wr_mem_wr", mem_wr, 1);
        check_value("b_wr_wdata", mem_wdata, 8'hC3);
        check_value("b_wr_addr", mem_addr, 23'h000123);
        b_req = 1'b0;          // dropped after grant: access must still complete
        wait_ack(1'b1, 10, cyc);
        check_value("b_wr_ack_lat", cyc, 2);
        check_value("b_wr_dout_kept", b_dout, 8'h00);
        rd_val = 8'h11;
        b_wr   = 1'b0;
        b_req  = 1'b1;
        tick(1);
        check_value("b_ack_cycle_masked", mem_req, 0);
        wait_ack(1'b1, 10, cyc);
        check_value("b_rd_ack_lat", cyc, 3);
        check_value("b_rd_dout", b_dout, 8'h11);
        b_req    = 1'b0;
        inj_done = 1'b1;
        tick(1);
        inj_done = 1'b0;
        check_value("idle_done_b_ack", b_ack, 0);
        check_value("idle_done_busy", busy, 0);
        check_value("idle_done_b_dout", b_dout, 8'h11);

        // ---------------- Reset pulsed during ACCESS_B ----------------
        b_ack_base = b_ack_cnt;
        lat    = 5;
        rd_val = 8'h99;
        b_wr   = 1'b0;
        b_addr = 23'h000456;
        b_req  = 1'b1;
        tick(1);
        check_value("b_abort_started", mem_req, 1);
        tick(1);
        reset_n = 1'b0;
        #1;
        check_value("b_abort_mem_req", mem_req, 0);
        check_value("b_abort_busy", busy, 0);
        check_value("b_abort_addr", mem_addr, 23'd0);
        check_value("b_abort_wdata", mem_wdata, 8'h00);
        check_value("b_abort_b_dout", b_dout, 8'h00);
        check_value("b_abort_b_ack", b_ack, 0);
        lat = 1;
        tick(1);
        reset_n = 1'b1;
        wait_ack(1'b1, 10, cyc);
        check_value("b_after_rst_ack_lat", cyc, 3);
        check_value("b_after_rst_dout", b_dout, 8'h99);
        b_req = 1'b0;
        tick(2);
        check_value("b_abort_ack_count", b_ack_cnt - b_ack_base, 1);

        // ---------------- Round-robin with both ports held ----------------
        do_reset();
        lat    = 1;
        a_wr   = 1'b1;
        b_wr   = 1'b1;
        a_addr = c_addr_a;
        b_addr = c_addr_b;
        a_din  = 8'hAA;
        b_din  = 8'hBB;
        s      = grant_log.size();
        a_req  = 1'b1;
        b_req  = 1'b1;
        tick(40);
        a_req = 1'b0;
        b_req = 1'b0;
        tick(6);
        check_value("rr_enough_grants", (grant_log.size() - s) >= 8, 1);
        if (grant_log.size() >= s + 4) begin
            check_value("rr_grant0", grant_log[s],     c_addr_a);
            check_value("rr_grant1", grant_log[s + 1], c_addr_b);
            check_value("rr_grant2", grant_log[s + 2], c_addr_a);
            check_value("rr_grant3", grant_log[s + 3], c_addr_b);
        end
        same_cnt = 0;
        for (int i = s + 1; i < grant_log.size(); i++) begin
            if (grant_log[i] == grant_log[i - 1]) same_cnt++;
        end
        check_value("rr_no_repeat", same_cnt, 0);

        // ---------------- Periodic refresh with no requests ----------------
        do_reset();
        lat = 1;
        tick(16);
        check_value("ref1_not_yet", mem_refresh, 0);
        tick(1);
        check_value("ref1_rise", mem_refresh, 1);
        check_value("ref1_busy", busy, 1);
        check_value("ref1_no_req", mem_req, 0);
        tick(15);
        check_value("ref2_not_yet", mem_refresh, 0);
        tick(1);
        check_value("ref2_rise", mem_refresh, 1);

        // ---------------- Forced refresh with A held ----------------
        do_reset();
        lat    = 1;
        rd_val = 8'h3C;
        a_wr   = 1'b0;
        a_addr = c_addr_a;
        a_req  = 1'b1;
        tick(20);
        check_value("force_deferred", mem_refresh, 0);
        tick(1);
        check_value("force_granted", mem_refresh, 1);
        check_value("force_no_req", mem_req, 0);
        tick(2);
        check_value("force_done", mem_refresh, 0);
        tick(1);
        check_value("force_a_resumes", mem_req, 1);
        check_value("force_a_dout", a_dout, 8'h3C);
        a_req = 1'b0;
        tick(5);

        check_value("no_req_refresh_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
